// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program-counter register and instruction-fetch sequencer.
//               Holds the current PC, issues one instruction-memory request
//               per PC over a valid/ready handshake, captures the returned
//               word and presents it, with its PC, to decode over a second
//               valid/ready handshake. The next PC is supplied from outside
//               by the next-address adder; no PC arithmetic happens here.
//
// Ports       :
//   clk            in   1        system clock, rising-edge active
//   rst            in   1        asynchronous active-high reset
//   next_pc        in   32       next PC from the next-address adder
//   pc_update      in   1        next_pc valid (current instruction done)
//   imem_req_valid out  1        fetch request valid
//   imem_req_addr  out  32       fetch address (always the current PC)
//   imem_req_ready in   1        memory accepts request
//   imem_rsp_valid in   1        returned instruction word valid
//   imem_rsp_data  in   32       returned instruction word
//   inst_valid     out  1        instruction available to decode
//   inst_ready     in   1        decode accepts instruction
//   inst           out  32       captured instruction
//   inst_pc        out  32       PC of the captured instruction
//   misalign       out  1        sticky fault: a misaligned next_pc was taken
//   fetch_count    out  COUNT_W  instructions handed to decode (wrapping)
//
// Revision    : 1.0  initial release
// ============================================================================
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        next_pc,
    input  logic               pc_update,
    output logic               imem_req_valid,
    output logic [31:0]        imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [31:0]        imem_rsp_data,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [31:0]        inst,
    output logic [31:0]        inst_pc,
    output logic               misalign,
    output logic [COUNT_W-1:0] fetch_count
);

    // ------------------------------------------------------------------------
    // Sequencer states
    //   IDLE  : one cycle after reset release before the first request
    //   REQ   : request presented, waiting for the memory to accept it
    //   WAIT  : request accepted, waiting for the instruction word
    //   HOLD  : instruction presented to decode
    //   EXEC  : decode has the instruction, waiting for the next PC
    //   FAULT : a misaligned PC was taken; terminal until reset
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_EXEC  = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    localparam logic [COUNT_W-1:0] c_count_one = {{(COUNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_inst;
    logic [31:0]        r_inst_pc;
    logic [COUNT_W-1:0] r_fetch_count;

    // Instructions are 4-byte aligned; any low address bit set is a fault.
    logic w_next_misaligned;
    assign w_next_misaligned = |next_pc[1:0];

    // Destination once a new PC is taken, shared by the HOLD and EXEC paths.
    state_t w_after_update;
    assign w_after_update = w_next_misaligned ? ST_FAULT : ST_REQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_inst        <= 32'h0000_0000;
            r_inst_pc     <= RESET_PC;
            r_fetch_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_REQ;
                end

                ST_REQ: begin
                    // Address is r_pc, which cannot change in this state, so
                    // the request stays stable until accepted.
                    if (imem_req_ready) begin
                        r_state <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        r_inst    <= imem_rsp_data;
                        r_inst_pc <= r_pc;
                        r_state   <= ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    if (inst_ready) begin
                        r_fetch_count <= r_fetch_count + c_count_one;
                        // A next PC arriving with the accept skips EXEC, which
                        // gives the 3-cycle back-to-back fetch loop.
                        if (pc_update) begin
                            r_pc    <= next_pc;
                            r_state <= w_after_update;
                        end else begin
                            r_state <= ST_EXEC;
                        end
                    end
                end

                ST_EXEC: begin
                    if (pc_update) begin
                        r_pc    <= next_pc;
                        r_state <= w_after_update;
                    end
                end

                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are pure decodes of registered state, so they are glitch-free
    // with respect to the inputs.
    assign imem_req_valid = (r_state == ST_REQ);
    assign imem_req_addr  = r_pc;
    assign inst_valid     = (r_state == ST_HOLD);
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;
    assign misalign       = (r_state == ST_FAULT);
    assign fetch_count    = r_fetch_count;

endmodule
`default_nettype wire

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer for the RISC-V CPU.
- Sits directly downstream of the next-address adder: it consumes the computed next PC and turns it into the registered PC.
- Issues one instruction-memory request per PC over a valid/ready handshake and captures the returned word.
- Presents the instruction and its PC to decode through a valid/ready handshake.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- COUNT_W, 32, width of the fetched-instruction counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- next_pc  input  32  next PC from the next-address adder
- pc_update  input  1  next_pc is valid this cycle (current instruction finished)
- imem_req_valid  output  1  fetch request valid
- imem_req_addr  output  32  fetch address (= current PC)
- imem_req_ready  input  1  memory accepts request
- imem_rsp_valid  input  1  instruction word valid
- imem_rsp_data  input  32  instruction word
- inst_valid  output  1  instruction available to decode
- inst_ready  input  1  decode accepts instruction
- inst  output  32  captured instruction
- inst_pc  output  32  PC of captured instruction (currentPC for next-address logic)
- misalign  output  1  sticky fault: next_pc[1:0] != 0
- fetch_count  output  COUNT_W  number of instructions handed to decode

Behaviour:
- Reset (async, rst=1) values:
  - pc=RESET_PC, state=IDLE, inst=0, inst_pc=RESET_PC, misalign=0, fetch_count=0.
  - All valid outputs are 0.
- Outputs are decoded from registered state only: imem_req_valid=1 only in REQ; inst_valid=1 only in HOLD. imem_req_addr=pc at all times.
- IDLE: unconditional move to REQ on the first edge after rst deasserts.
- REQ: wait for imem_req_ready.
  - req_valid and addr stay stable until accepted.
  - Handshake (valid&ready) -> WAIT.
- WAIT: wait for imem_rsp_valid.
  - On rsp_valid, capture inst<=imem_rsp_data and inst_pc<=pc, then -> HOLD.
  - Earliest inst_valid is therefore 2 cycles after the request handshake.
- HOLD: inst_valid=1; inst and inst_pc are held stable.
  - On inst_ready, fetch_count increments by 1 and wraps modulo 2^COUNT_W -> EXEC.
  - pc_update in the same cycle as inst_ready is also accepted: pc<=next_pc, then -> REQ, or -> FAULT if misaligned.
- EXEC: wait for pc_update.
  - On pc_update, pc<=next_pc.
  - If next_pc[1:0]!=0 -> FAULT; else -> REQ.
- FAULT: misalign=1, no requests, no inst_valid. Terminal until reset. pc holds the faulting address.
- Ignored inputs:
  - pc_update in IDLE, REQ, WAIT or FAULT, and in HOLD without inst_ready.
  - imem_rsp_valid outside WAIT.
  - At most one request is outstanding.
- Back-to-back operation: with ready/rsp always high and pc_update in the HOLD accept cycle, one instruction is delivered every 3 cycles (REQ, WAIT, HOLD).
- Reset mid-operation: any state returns to IDLE immediately. A partially received response is dropped. The memory shares rst, so no stale response follows.
- No arithmetic on the PC is done here; the increment and branch targets come from the next-address stage.

Test Plan:
- Reset release, RESET_PC=0, memory always ready, rsp 1 cycle after request with data 32'h00000013:
  - req_valid=1 with addr=0 in cycle 1.
  - inst_valid=1 with inst=32'h00000013, inst_pc=0 in cycle 3.
  - fetch_count=1 after inst_ready.
- Sequential fetch, pc_update with next_pc=4, 8, 12 in each HOLD accept cycle:
  - imem_req_addr sequence is 0, 4, 8, 12.
  - After 3 accepts, fetch_count=3, and inst_pc matches each address.
- Backpressure:
  - imem_req_ready low for 4 cycles: req_valid and addr stay constant.
  - inst_ready low for 5 cycles: inst, inst_pc and inst_valid stay stable, and fetch_count does not change.
- Branch then fault:
  - next_pc=32'h00000100 -> next request addr=32'h100.
  - next_pc=32'h00000102 -> misalign=1, req_valid stays 0 for 10+ cycles, pc=32'h102. Reset clears misalign.
- Spurious inputs:
  - pc_update pulses during REQ and WAIT leave pc unchanged.
  - rsp_valid during REQ is not captured; inst stays at its old value.
- Async reset asserted mid-WAIT: all outputs return to reset values immediately without a clock edge. After release, the first request is at RESET_PC.
